// File: rtl/conv_window_gen_pkg.sv
// Shared 3x3 window constants and packing helpers.
// Element k = row*3+col sits at bits [(k+1)*PIX_W-1 -: PIX_W].
package conv_window_gen_pkg;

  localparam int KERNEL_SIZE = 3;
  localparam int PIX_W       = 8;
  localparam int WIN_W       = KERNEL_SIZE * KERNEL_SIZE * PIX_W;

  function automatic int idx(input int row, input int col);
    return row * KERNEL_SIZE + col;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixels; single address, read-before-write.
// Contents are not reset: every entry is rewritten before use.
module conv_line_buffer #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator for raster-order pixels.
// Single output register stage with combinational ready pass-through.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = PIX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   pixel_in,
  input  logic                pixel_valid,
  output logic                pixel_ready,
  output logic [9*DATA_W-1:0] window,
  output logic                win_valid,
  input  logic                win_ready,
  output logic                win_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] lb0_q;
  logic [DATA_W-1:0] lb1_q;
  logic [DATA_W-1:0] win [KERNEL_SIZE][KERNEL_SIZE];
  logic [DATA_W-1:0] new_col [KERNEL_SIZE];
  logic              accept;
  logic              last_col;
  logic              last_row;
  logic              qual;

  assign pixel_ready = !win_valid || win_ready;
  assign accept      = pixel_valid && pixel_ready;
  assign last_col    = (col == COL_MAX);
  assign last_row    = (row == ROW_MAX);
  assign qual        = (row >= RW'(2)) && (col >= CW'(2));

  assign new_col[0] = lb0_q;
  assign new_col[1] = lb1_q;
  assign new_col[2] = pixel_in;

  conv_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
    .clk   (clk),
    .en    (accept),
    .addr  (col),
    .wdata (lb1_q),
    .rdata (lb0_q)
  );

  conv_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk   (clk),
    .en    (accept),
    .addr  (col),
    .wdata (pixel_in),
    .rdata (lb1_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      for (int r = 0; r < KERNEL_SIZE; r++)
        for (int c = 0; c < KERNEL_SIZE; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      // Columns are not cleared at row start; c<2 windows are suppressed
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
        win[r][2] <= new_col[r];
      end
      win_valid <= qual;
      win_last  <= qual && last_row && last_col;
    end else if (win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

  always_comb begin
    window = '0;
    for (int r = 0; r < KERNEL_SIZE; r++)
      for (int c = 0; c < KERNEL_SIZE; c++)
        window[idx(r, c)*DATA_W +: DATA_W] = win[r][c];
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x4 image.
// Expected windows come from a hand-written table.
module tb_conv_window_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [71:0] window;
  logic        win_valid;
  logic        win_ready;
  logic        win_last;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [71:0] win;
    logic        last;
  } vec_t;

  vec_t tbl [4];
  vec_t got [$];
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  conv_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .window      (window),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_last    (win_last)
  );

  always @(negedge clk) begin
    if (mon_en && win_valid && win_ready)
      got.push_back('{win: window, last: win_last});
  end

  function automatic logic [71:0] pk(input int e0, e1, e2, e3, e4,
                                     e5, e6, e7, e8);
    logic [7:0] b [9];
    logic [71:0] w;
    b = '{e0[7:0], e1[7:0], e2[7:0], e3[7:0], e4[7:0],
          e5[7:0], e6[7:0], e7[7:0], e8[7:0]};
    w = '0;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = b[k];
    return w;
  endfunction

  function automatic logic [71:0] addb(input logic [71:0] w,
                                       input logic [7:0] d);
    logic [71:0] o;
    for (int k = 0; k < 9; k++) o[k*8 +: 8] = w[k*8 +: 8] + d;
    return o;
  endfunction

  function automatic int wsum(input logic [71:0] w);
    int s = 0;
    for (int k = 0; k < 9; k++) s += int'($signed(w[k*8 +: 8]));
    return s;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold pixel until accepted; optional valid bubbles and ready noise
  task automatic push(input logic [7:0] p, input bit bub, input bit rnd);
    bit acc;
    int guard;
    guard = 0;
    acc = 1'b0;
    pixel_in = p;
    while (!acc) begin
      pixel_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
      win_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = pixel_valid && pixel_ready;
      tick();
      guard++;
      if (guard > 200) begin
        chk("push_timeout", 72'(guard), 72'd0);
        acc = 1'b1;
      end
    end
    pixel_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] base, input bit bub, input bit rnd);
    for (int n = 0; n < 16; n++) push(base + 8'(n), bub, rnd);
  endtask

  task automatic drain();
    pixel_valid = 1'b0;
    win_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic cmp_frames(input string nm, input int nf,
                            input logic [7:0] base2);
    chk({nm, "_count"}, 72'(got.size()), 72'(4 * nf));
    for (int i = 0; i < got.size() && i < 4 * nf; i++) begin
      logic [71:0] ew;
      ew = (i >= 4) ? addb(tbl[i%4].win, base2) : tbl[i%4].win;
      chk($sformatf("%s_win%0d", nm, i), got[i].win, ew);
      chk($sformatf("%s_last%0d", nm, i), 72'(got[i].last),
          72'(tbl[i%4].last));
    end
  endtask

  initial begin
    int exp_sum [4];
    tbl[0] = '{pk(0, 1, 2, 4, 5, 6, 8, 9, 10), 1'b0};
    tbl[1] = '{pk(1, 2, 3, 5, 6, 7, 9, 10, 11), 1'b0};
    tbl[2] = '{pk(4, 5, 6, 8, 9, 10, 12, 13, 14), 1'b0};
    tbl[3] = '{pk(5, 6, 7, 9, 10, 11, 13, 14, 15), 1'b1};
    exp_sum = '{-387, 378, -387, 378};

    rst = 1'b1;
    pixel_in = '0;
    pixel_valid = 1'b0;
    win_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_win_valid", 72'(win_valid), 72'd0);
    chk("rst_win_last", 72'(win_last), 72'd0);
    chk("rst_window", window, 72'd0);
    chk("rst_pixel_ready", 72'(pixel_ready), 72'd1);
    tick();
    mon_en = 1'b1;

    // 1: continuous stream
    frame(8'd0, 1'b0, 1'b0);
    drain();
    cmp_frames("t1", 1, 8'd0);
    got.delete();

    // 2: backpressure once the first window appears
    for (int n = 0; n <= 10; n++) push(8'(n), 1'b0, 1'b0);
    chk("t2_first_valid", 72'(win_valid), 72'd1);
    pixel_in = 8'd11;
    pixel_valid = 1'b1;
    win_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t2_hold_win%0d", i), window, tbl[0].win);
      chk($sformatf("t2_hold_rdy%0d", i), 72'(pixel_ready), 72'd0);
      tick();
    end
    for (int n = 11; n < 16; n++) push(8'(n), 1'b0, 1'b0);
    drain();
    cmp_frames("t2", 1, 8'd0);
    got.delete();

    // 3: random valid bubbles and random ready
    frame(8'd0, 1'b1, 1'b1);
    drain();
    cmp_frames("t3", 1, 8'd0);
    got.delete();

    // 4: back-to-back frames
    frame(8'd0, 1'b0, 1'b0);
    frame(8'd100, 1'b0, 1'b0);
    drain();
    cmp_frames("t4", 2, 8'd100);
    if (got.size() >= 5)
      chk("t4_fifth", got[4].win, pk(100, 101, 102, 104, 105, 106,
                                     108, 109, 110));
    else
      chk("t4_fifth_missing", 72'(got.size()), 72'd5);
    got.delete();

    // 5: reset mid-frame after 7 pixels
    for (int n = 0; n < 7; n++) push(8'(n + 50), 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_rst_valid", 72'(win_valid), 72'd0);
    tick();
    frame(8'd0, 1'b0, 1'b0);
    drain();
    cmp_frames("t5", 1, 8'd0);
    got.delete();

    // 6: signed extremes, column parity alternates 80/7F
    for (int n = 0; n < 16; n++)
      push((n % 2 == 0) ? 8'h80 : 8'h7F, 1'b0, 1'b0);
    drain();
    chk("t6_count", 72'(got.size()), 72'd4);
    for (int i = 0; i < got.size() && i < 4; i++) begin
      logic [71:0] ew;
      ew = (i % 2 == 0)
        ? {3{8'h80, 8'h7F, 8'h80}} : {3{8'h7F, 8'h80, 8'h7F}};
      chk($sformatf("t6_win%0d", i), got[i].win, ew);
      chk($sformatf("t6_sum%0d", i), 72'(wsum(got[i].win)),
          72'(exp_sum[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "timeout");
  end

endmodule
